// File: rtl/xnor_pattern_detector.sv
// xnor_pattern_detector
//   Bitwise XNOR of each accepted word against a stored pattern, with
//   full-word equality flag, consecutive-match run counter, one-cycle
//   detection pulse and a saturating detection counter.
//   Optional feature macro: XNOR_MASK_EN (adds mask_in; masked-off bits
//   always count as equal in eq, xnor_out stays the raw XNOR).
module xnor_pattern_detector #(
  parameter  int WIDTH     = 8,
  parameter  int MATCH_LEN = 4,
  parameter  int CNT_W     = 8,
  localparam int RC_W      = $clog2(MATCH_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
`ifdef XNOR_MASK_EN
  input  logic [WIDTH-1:0] mask_in,
`endif
  output logic [WIDTH-1:0] xnor_out,
  output logic             eq,
  output logic [RC_W-1:0]  run_cnt,
  output logic             detect,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             armed
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SEARCH = 2'd1,
    HIT    = 2'd2
  } state_t;

  // Run count value at which the next matching sample completes a detection.
  localparam logic [RC_W-1:0] RUN_LAST = RC_W'(MATCH_LEN - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] xnor_q, xnor_d;
  logic             eq_q, eq_d;
  logic [RC_W-1:0]  run_q, run_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             armed_q, armed_d;

  logic [WIDTH-1:0] xnor_w;
  logic [WIDTH-1:0] cmp_w;
  logic             match_w;

  // Detection counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign xnor_w = ~(data_in ^ pat_q);
`ifdef XNOR_MASK_EN
  assign cmp_w  = xnor_w | ~mask_in;
`else
  assign cmp_w  = xnor_w;
`endif
  assign match_w = &cmp_w;

  // Next-state and datapath update; load wins over a same-cycle sample.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    xnor_d  = xnor_q;
    eq_d    = eq_q;
    run_d   = run_q;
    hit_d   = hit_q;
    armed_d = armed_q;
    case (state_q)
      EMPTY: begin
        if (load) begin
          pat_d   = pattern_in;
          armed_d = 1'b1;
          state_d = SEARCH;
        end
      end
      default: begin
        state_d = SEARCH;
        if (load) begin
          pat_d = pattern_in;
          run_d = '0;
        end else if (in_valid) begin
          xnor_d = xnor_w;
          eq_d   = match_w;
          if (match_w && (run_q == RUN_LAST)) begin
            run_d   = '0;
            hit_d   = sat_inc(hit_q);
            state_d = HIT;
          end else if (match_w) begin
            run_d = run_q + 1'b1;
          end else begin
            run_d = '0;
          end
        end
      end
    endcase
  end

  // State and output registers; reset returns to EMPTY and forgets the pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      pat_q   <= '0;
      xnor_q  <= '0;
      eq_q    <= 1'b0;
      run_q   <= '0;
      hit_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      xnor_q  <= xnor_d;
      eq_q    <= eq_d;
      run_q   <= run_d;
      hit_q   <= hit_d;
      armed_q <= armed_d;
    end
  end

  assign xnor_out = xnor_q;
  assign eq       = eq_q;
  assign run_cnt  = run_q;
  assign detect   = (state_q == HIT);
  assign hit_cnt  = hit_q;
  assign armed    = armed_q;

endmodule

// File: tb/tb_xnor_pattern_detector.sv
// Testbench for xnor_pattern_detector: scoreboard of expected outputs per
// driven cycle, plus a second instance with CNT_W=2 for saturation.
module tb_xnor_pattern_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] pattern_in;
  logic       in_valid;
  logic [7:0] data_in;
`ifdef XNOR_MASK_EN
  logic [7:0] mask_in;
`endif

  logic [7:0] xnor_out;
  logic       eq;
  logic [2:0] run_cnt;
  logic       detect;
  logic [7:0] hit_cnt;
  logic       armed;

  logic [7:0] s_xnor;
  logic       s_eq;
  logic [2:0] s_run;
  logic       s_det;
  logic [1:0] s_hit;
  logic       s_armed;

  always #5 clk = ~clk;

  xnor_pattern_detector #(.WIDTH(8), .MATCH_LEN(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .load(load), .pattern_in(pattern_in),
    .in_valid(in_valid), .data_in(data_in),
`ifdef XNOR_MASK_EN
    .mask_in(mask_in),
`endif
    .xnor_out(xnor_out), .eq(eq), .run_cnt(run_cnt), .detect(detect),
    .hit_cnt(hit_cnt), .armed(armed)
  );

  xnor_pattern_detector #(.WIDTH(8), .MATCH_LEN(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .load(load), .pattern_in(pattern_in),
    .in_valid(in_valid), .data_in(data_in),
`ifdef XNOR_MASK_EN
    .mask_in(mask_in),
`endif
    .xnor_out(s_xnor), .eq(s_eq), .run_cnt(s_run), .detect(s_det),
    .hit_cnt(s_hit), .armed(s_armed)
  );

  typedef struct {
    logic [7:0] xnor_v;
    logic       eq_v;
    logic [2:0] run_v;
    logic       det_v;
    logic [7:0] hit_v;
    logic [1:0] hit2_v;
    logic       armed_v;
  } exp_t;

  exp_t sbq[$];

  int n_total = 0;
  int n_bad   = 0;
  int det_seen = 0;

  // reference model state
  logic [7:0] m_pat;
  logic       m_armed;
  logic [7:0] m_xnor;
  logic       m_eq;
  logic [2:0] m_run;
  logic       m_det;
  int         m_hits;

  localparam logic [7:0] ALL = 8'hFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] p,
                      input logic v, input logic [7:0] d, input logic [7:0] m);
    exp_t e;
    logic [7:0] x;
    rst = r; load = l; pattern_in = p; in_valid = v; data_in = d;
`ifdef XNOR_MASK_EN
    mask_in = m;
`endif
    if (r) begin
      m_pat = 8'h00; m_armed = 1'b0; m_xnor = 8'h00; m_eq = 1'b0;
      m_run = 3'd0; m_det = 1'b0; m_hits = 0;
    end else if (!m_armed) begin
      if (l) begin
        m_pat = p; m_armed = 1'b1;
      end
    end else if (l) begin
      m_pat = p; m_run = 3'd0; m_det = 1'b0;
    end else if (v) begin
      x = ~(d ^ m_pat);
      m_xnor = x;
      m_eq = &(x | ~m);
      m_det = 1'b0;
      if (!m_eq) m_run = 3'd0;
      else if (m_run == 3'd3) begin
        m_run = 3'd0; m_det = 1'b1; m_hits++;
      end else m_run = m_run + 3'd1;
    end else begin
      m_det = 1'b0;
    end
    e.xnor_v  = m_xnor;
    e.eq_v    = m_eq;
    e.run_v   = m_run;
    e.det_v   = m_det;
    e.hit_v   = (m_hits > 255) ? 8'd255 : 8'(m_hits);
    e.hit2_v  = (m_hits > 3) ? 2'd3 : 2'(m_hits);
    e.armed_v = m_armed;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("xnor_out", 32'(xnor_out), 32'(e.xnor_v));
    chk("eq",       32'(eq),       32'(e.eq_v));
    chk("run_cnt",  32'(run_cnt),  32'(e.run_v));
    chk("detect",   32'(detect),   32'(e.det_v));
    chk("hit_cnt",  32'(hit_cnt),  32'(e.hit_v));
    chk("armed",    32'(armed),    32'(e.armed_v));
    chk("sat_hit",  32'(s_hit),    32'(e.hit2_v));
    chk("sat_run",  32'(s_run),    32'(e.run_v));
    chk("sat_det",  32'(s_det),    32'(e.det_v));
    chk("sat_xnor", 32'({s_xnor, s_eq, s_armed}), 32'({e.xnor_v, e.eq_v, e.armed_v}));
    if (detect) det_seen++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, ALL);
  endtask

  task automatic feed(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, d, ALL);
  endtask

  initial begin
    // reset, then samples with no pattern are ignored
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ALL);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ALL);
    chk("rst_armed", 32'(armed), 32'd0);
    feed(8'hA5, 3);
    chk("empty_xnor", 32'(xnor_out), 32'd0);
    chk("empty_armed", 32'(armed), 32'd0);

    // single mismatching sample
    step(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, ALL);
    chk("load_armed", 32'(armed), 32'd1);
    feed(8'h3D, 1);
    chk("tp2_xnor", 32'(xnor_out), 32'hFE);
    chk("tp2_eq", 32'(eq), 32'd0);

    // nine matches: detections after 4th and 8th
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ALL);
    step(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, ALL);
    det_seen = 0;
    feed(8'h3C, 9);
    chk("tp3_dets", 32'(det_seen), 32'd2);
    chk("tp3_hit", 32'(hit_cnt), 32'd2);
    chk("tp3_run", 32'(run_cnt), 32'd1);

    // gap does not break a run; a mismatch does
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ALL);
    step(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, ALL);
    feed(8'h3C, 3);
    idle_n(1);
    chk("gap_run_hold", 32'(run_cnt), 32'd3);
    feed(8'h3C, 1);
    chk("gap_detect", 32'(detect), 32'd1);
    feed(8'h3C, 3);
    feed(8'h00, 1);
    feed(8'h3C, 1);
    chk("brk_run", 32'(run_cnt), 32'd1);
    chk("brk_detect", 32'(detect), 32'd0);

    // load mid-run drops the same-cycle sample and clears the run
    feed(8'h3C, 1);
    step(1'b0, 1'b1, 8'h0F, 1'b1, 8'h3C, ALL);
    chk("ld_run", 32'(run_cnt), 32'd0);
    feed(8'h0F, 4);
    chk("ld_detect", 32'(detect), 32'd1);

    // saturation: 5 detections
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ALL);
    step(1'b0, 1'b1, 8'h55, 1'b0, 8'h00, ALL);
    feed(8'h55, 20);
    chk("sat_hit3", 32'(s_hit), 32'd3);
    chk("hit5", 32'(hit_cnt), 32'd5);

    // reset clears everything
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ALL);
    chk("rst_all", 32'({xnor_out, eq, run_cnt, detect, hit_cnt, armed}), 32'd0);

`ifdef XNOR_MASK_EN
    step(1'b0, 1'b1, 8'hA0, 1'b0, 8'h00, ALL);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hA7, 8'hF0);
    chk("mask_eq", 32'(eq), 32'd1);
    chk("mask_xnor", 32'(xnor_out), 32'hF8);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h00);
    chk("mask_zero_eq", 32'(eq), 32'd1);
`endif

    // randomised traffic over a small value set so matches are frequent
    for (int i = 0; i < 400; i++) begin
      logic [7:0] rm;
`ifdef XNOR_MASK_EN
      rm = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 255);
`else
      rm = ALL;
`endif
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           8'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 3)), rm);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/xnor_pattern_detector.md
# xnor_pattern_detector

Parametrised, clocked successor to the single-bit structural XNOR gate. Registers a WIDTH-bit bitwise XNOR of each accepted input word against a stored pattern and flags full-word equality. Counts consecutive equal words and pulses `detect` after MATCH_LEN in a row. Sits downstream of the lab datapath blocks as a sequence/pattern monitor.

## Interface
- `WIDTH`, 8: data and pattern width in bits (≥1).
- `MATCH_LEN`, 4: consecutive matches needed for a detection (≥1).
- `CNT_W`, 8: width of the detection hit counter.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load`  in  1  capture `pattern_in` as the new pattern.
- `pattern_in`  in  WIDTH  pattern value, sampled when `load`=1.
- `in_valid`  in  1  `data_in` is valid this cycle.
- `data_in`  in  WIDTH  word to compare.
- `mask_in`  in  WIDTH  per-bit compare enable, 1 = compare; present only with `XNOR_MASK_EN`.
- `xnor_out`  out  WIDTH  registered `~(data_in ^ pattern)` of the last accepted word.
- `eq`  out  1  registered: last accepted word equalled the pattern.
- `run_cnt`  out  $clog2(MATCH_LEN+1)  current consecutive-match count.
- `detect`  out  1  one-cycle pulse on a completed run.
- `hit_cnt`  out  CNT_W  number of detections, saturating.
- `armed`  out  1  a pattern has been loaded.

## Operation
- States: EMPTY (no pattern), SEARCH, HIT.
- Reset → EMPTY. Reset values: `xnor_out`=0, `eq`=0, `run_cnt`=0, `detect`=0, `hit_cnt`=0, `armed`=0, pattern register=0.
- EMPTY: `in_valid` is ignored and outputs hold. `load`=1 → store pattern, `armed`←1, go to SEARCH.
- SEARCH/HIT, accepted sample (`in_valid`=1, `load`=0):
  - `xnor_out` ← `~(data_in ^ pattern)`.
  - `eq` ← AND of all `xnor_out` bits.
  - If `eq` and `run_cnt`+1 = MATCH_LEN: `run_cnt`←0, `detect`←1, `hit_cnt`←`hit_cnt`+1 (saturates at 2^CNT_W−1), go to HIT.
  - Else if `eq`: `run_cnt`←`run_cnt`+1, go to SEARCH.
  - Else: `run_cnt`←0, go to SEARCH.
- Detection is non-overlapping. The run restarts from 0 after each hit.
- HIT: `detect`=1 for exactly one cycle. The next edge returns to SEARCH unless another hit completes; with MATCH_LEN=1 and back-to-back matches, `detect` stays high.
- No valid sample in SEARCH/HIT: `xnor_out`, `eq`, and `run_cnt` hold. `detect`←0. HIT → SEARCH.
- `load` in SEARCH/HIT:
  - New pattern stored; `run_cnt`←0, `detect`←0.
  - `xnor_out`/`eq` hold; `hit_cnt` holds.
  - `load` has priority over `in_valid`; a same-cycle sample is dropped.
- `rst` has priority over everything. Reset mid-run clears the run and hit count and returns to EMPTY (pattern lost).

## Timing
- One-cycle latency: a sample accepted at edge k appears on `xnor_out`/`eq`/`run_cnt`/`detect` after edge k.
- A new pattern applies to samples accepted from the edge after `load`.
- No backpressure; one sample per cycle is accepted at full rate.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `XNOR_MASK_EN` defined:
  - `mask_in` port exists.
  - `eq` ← AND of (`xnor_out` | ~`mask_in`).
  - `xnor_out` is unmasked raw XNOR.
  - `mask_in` is sampled with `data_in`.
  - An all-zero mask makes every accepted word match.
- Undefined: no `mask_in` port; all bits are compared.

## Test plan
- Reset then `in_valid`=1, `data_in`=8'hA5, no load → all outputs stay 0, `armed`=0.
- Load 8'h3C, then one cycle later `data_in`=8'h3D → `xnor_out`=8'hFE, `eq`=0, `run_cnt`=0.
- Load 8'h3C (MATCH_LEN=4), then feed 8'h3C ×9 → `detect` pulses after the 4th and 8th samples only, `hit_cnt`=2, `run_cnt`=1 at the end.
- Three matches, one gap cycle (`in_valid`=0), then one match → `detect` after the 4th match, proving gaps do not break the run. Three matches then 8'h00 then one match → `run_cnt`=1, no detect.
- Mid-run `load`=1 with `in_valid`=1 and `pattern_in`=8'h0F → sample dropped, `run_cnt`=0. Following 8'h0F ×4 → `detect`. Then `rst` → all outputs 0, `armed`=0.
- CNT_W=2: 5 detections → `hit_cnt` saturates at 3. With `XNOR_MASK_EN`, `mask_in`=8'hF0, pattern 8'hA0, data 8'hA7 → `eq`=1, `xnor_out`=8'hF8.
